// File: rtl/shiftout_arbiter.sv
// shiftout_arbiter: round-robin arbiter feeding two requesters' 16-bit words to one shift-out engine.
// Optional macro SHIFTOUT_ARB_TIMEOUT_EN adds a WAIT_DONE timeout that aborts with timeout_out.
module shiftout_arbiter #(
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        req0_in,
    input  logic        req1_in,
    input  logic [15:0] data0_in,
    input  logic [15:0] data1_in,
    output logic        ack0_out,
    output logic        ack1_out,
    output logic        so_start_out,
    output logic [15:0] so_bits_out,
    input  logic        so_done_in,
    output logic        busy_out,
    output logic        grant_out,
    output logic        timeout_out
);
    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, ACK} state_t;

    localparam logic [3:0] SC = 4'(START_CYCLES);

    if (START_CYCLES < 1 || START_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("shiftout_arbiter: parameter out of range");
    end

    state_t     state;
    logic [3:0] cnt;
    logic       first;
    logic       last;
    logic       ready;
    logic       sel;
    logic       any_req;
`ifdef SHIFTOUT_ARB_TIMEOUT_EN
    localparam logic [7:0] TC = 8'(TIMEOUT_CYCLES);
    logic [7:0] tcnt;
`endif

    // Contention goes to whoever was not served last; a lone request always wins.
    always_comb begin
        any_req = req0_in | req1_in;
        sel     = (req0_in & req1_in) ? ~last : req1_in;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state        <= IDLE;
            cnt          <= '0;
            first        <= 1'b0;
            last         <= 1'b1;
            ready        <= 1'b0;
            ack0_out     <= 1'b0;
            ack1_out     <= 1'b0;
            so_start_out <= 1'b0;
            so_bits_out  <= '0;
            busy_out     <= 1'b0;
            grant_out    <= 1'b0;
            timeout_out  <= 1'b0;
`ifdef SHIFTOUT_ARB_TIMEOUT_EN
            tcnt         <= '0;
`endif
        end else begin
            // ready delays the first grant by one edge after reset release
            ready       <= 1'b1;
            ack0_out    <= 1'b0;
            ack1_out    <= 1'b0;
            timeout_out <= 1'b0;
            case (state)
                IDLE: if (ready && any_req) begin
                    state        <= START;
                    so_start_out <= 1'b1;
                    so_bits_out  <= sel ? data1_in : data0_in;
                    grant_out    <= sel;
                    busy_out     <= 1'b1;
                    cnt          <= 4'd1;
                end
                START: if (cnt == SC) begin
                    state        <= WAIT_DONE;
                    so_start_out <= 1'b0;
                    first        <= 1'b1;
`ifdef SHIFTOUT_ARB_TIMEOUT_EN
                    tcnt         <= 8'd1;
`endif
                end else begin
                    cnt <= cnt + 4'd1;
                end
                WAIT_DONE: begin
                    // done in the first WAIT_DONE cycle may be left over from the previous word
                    first <= 1'b0;
`ifdef SHIFTOUT_ARB_TIMEOUT_EN
                    tcnt  <= tcnt + 8'd1;
`endif
                    if (!first && so_done_in) begin
                        state    <= ACK;
                        ack0_out <= ~grant_out;
                        ack1_out <= grant_out;
                    end
`ifdef SHIFTOUT_ARB_TIMEOUT_EN
                    else if (tcnt == TC) begin
                        state       <= ACK;
                        ack0_out    <= ~grant_out;
                        ack1_out    <= grant_out;
                        timeout_out <= 1'b1;
                    end
`endif
                end
                ACK: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                    last     <= grant_out;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shiftout_arbiter.sv
// tb_shiftout_arbiter: directed checks of grant order, start timing, done handling, timeout and reset.
module tb_shiftout_arbiter;
    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        req0_in, req1_in, so_done_in;
    logic [15:0] data0_in, data1_in;
    logic        ack0_out, ack1_out, so_start_out, busy_out, grant_out, timeout_out;
    logic [15:0] so_bits_out;
    int          checks = 0;
    int          failures = 0;

    shiftout_arbiter #(.START_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .req0_in(req0_in), .req1_in(req1_in),
        .data0_in(data0_in), .data1_in(data1_in),
        .ack0_out(ack0_out), .ack1_out(ack1_out),
        .so_start_out(so_start_out), .so_bits_out(so_bits_out),
        .so_done_in(so_done_in), .busy_out(busy_out),
        .grant_out(grant_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_start"}, {15'd0, so_start_out}, 16'd0);
        chk({tag, "_bits"}, so_bits_out, 16'd0);
        chk({tag, "_acks"}, {14'd0, ack1_out, ack0_out}, 16'd0);
        chk({tag, "_busy_grant_to"}, {13'd0, busy_out, grant_out, timeout_out}, 16'd0);
    endtask

    // One full transaction: grant, two START cycles, ignored first WAIT_DONE cycle, ack, back to IDLE.
    task automatic txn(input logic g, input logic [15:0] b, input logic early);
        so_done_in = early;
        tick();
        chk("txn_grant", {15'd0, grant_out}, {15'd0, g});
        chk("txn_bits", so_bits_out, b);
        chk("txn_start1", {14'd0, so_start_out, busy_out}, 16'h0003);
        tick();
        chk("txn_start2", {14'd0, so_start_out, ack0_out | ack1_out}, 16'h0002);
        tick();
        chk("txn_wait_entry", {14'd0, so_start_out, ack0_out | ack1_out}, 16'h0000);
        so_done_in = 1'b1;
        tick();
        chk("txn_first_wait_ignored", {14'd0, ack1_out, ack0_out}, 16'd0);
        tick();
        chk("txn_ack", {13'd0, ack1_out, ack0_out, timeout_out}, {13'd0, g, ~g, 1'b0});
        so_done_in = 1'b0;
        tick();
        chk("txn_idle", {13'd0, busy_out, ack1_out, ack0_out}, 16'd0);
        chk("txn_bits_hold", so_bits_out, b);
    endtask

    initial begin
        reset_n_in = 1'b0;
        req0_in = 1'b0; req1_in = 1'b0; so_done_in = 1'b0;
        data0_in = 16'h0000; data1_in = 16'h0000;
        #1;
        chk_idle_outputs("reset");
        tick(); tick();

        // Single word from requester 0
        req0_in = 1'b1; data0_in = 16'hA5C3; reset_n_in = 1'b1;
        tick();
        chk("no_grant_first_edge", {15'd0, busy_out}, 16'd0);
        tick();
        chk("t1_grant", {14'd0, so_start_out, grant_out}, 16'h0002);
        chk("t1_bits", so_bits_out, 16'hA5C3);
        req0_in = 1'b0;
        tick();
        chk("t1_start2", {14'd0, so_start_out, busy_out}, 16'h0003);
        tick();
        chk("t1_start_drop", {14'd0, so_start_out, busy_out}, 16'h0001);
        repeat (16) tick();
        chk("t1_no_early_ack", {14'd0, ack1_out, ack0_out}, 16'd0);
        so_done_in = 1'b1;
        tick();
        chk("t1_ack0", {14'd0, ack1_out, ack0_out}, 16'h0001);
        so_done_in = 1'b0;
        tick();
        chk("t1_after", {13'd0, busy_out, ack1_out, ack0_out}, 16'd0);
        chk("t1_bits_hold", so_bits_out, 16'hA5C3);

        // Contention from reset: requester 0 first, then alternating
        reset_n_in = 1'b0;
        #1;
        chk_idle_outputs("reset2");
        tick();
        req0_in = 1'b1; req1_in = 1'b1; data0_in = 16'h1111; data1_in = 16'h2222;
        reset_n_in = 1'b1;
        tick();
        chk("rr_no_grant_first_edge", {15'd0, busy_out}, 16'd0);
        txn(1'b0, 16'h1111, 1'b0);
        txn(1'b1, 16'h2222, 1'b0);
        txn(1'b0, 16'h1111, 1'b0);
        txn(1'b1, 16'h2222, 1'b0);
        req0_in = 1'b0; req1_in = 1'b0;
        tick();
        chk("rr_idle", {15'd0, busy_out}, 16'd0);

        // Lone requester 1 wins although it was served last
        req1_in = 1'b1;
        txn(1'b1, 16'h2222, 1'b0);
        req1_in = 1'b0;

        // done held high through START is ignored
        req0_in = 1'b1;
        txn(1'b0, 16'h1111, 1'b1);
        req0_in = 1'b0;

        // done never arrives
        req1_in = 1'b1;
        tick();
        chk("to_grant", {14'd0, busy_out, grant_out}, 16'h0003);
        tick(); tick();
        repeat (7) tick();
        chk("to_before_limit", {13'd0, busy_out, ack1_out, timeout_out}, 16'h0004);
        tick();
`ifdef SHIFTOUT_ARB_TIMEOUT_EN
        chk("to_ack_timeout", {13'd0, ack0_out, ack1_out, timeout_out}, 16'h0003);
        tick();
        chk("to_after", {13'd0, busy_out, ack1_out, timeout_out}, 16'd0);
        tick();
        chk("to_regrant", {14'd0, busy_out, grant_out}, 16'h0003);
        tick(); tick();
`else
        chk("to_still_waiting", {13'd0, busy_out, ack1_out, timeout_out}, 16'h0004);
        repeat (20) tick();
        chk("to_busy_forever", {13'd0, busy_out, ack1_out, timeout_out}, 16'h0004);
`endif

        // Reset during WAIT_DONE, then req1 is served normally
        so_done_in = 1'b1;
        reset_n_in = 1'b0;
        #1;
        chk_idle_outputs("reset3");
        tick();
        chk("reset3_no_ack", {14'd0, ack1_out, ack0_out}, 16'd0);
        so_done_in = 1'b0;
        reset_n_in = 1'b1;
        tick();
        chk("r3_no_grant_first_edge", {15'd0, busy_out}, 16'd0);
        tick();
        chk("r3_grant", {14'd0, so_start_out, grant_out}, 16'h0003);
        chk("r3_bits", so_bits_out, 16'h2222);
        req1_in = 1'b0;
        tick(); tick();
        so_done_in = 1'b1;
        tick(); tick();
        chk("r3_ack1", {13'd0, ack1_out, ack0_out, timeout_out}, 16'h0004);
        so_done_in = 1'b0;
        tick();
        chk("r3_idle", {15'd0, busy_out}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
